mandelbrot_frame_scheduler: RTL

//  Sequences the recirculating pixel loop that feeds the fractal math stage.

---
 rtl/mandelbrot_frame_scheduler.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mandelbrot_frame_scheduler.sv
// rtl/mandelbrot_frame_scheduler.sv - seeds the pixel loop FIFO and sequences clear/iterate passes per frame
// Optional MFS_AUTO_REDRAW_EN: frames restart forever with the fractal mode toggled each frame.
module mandelbrot_frame_scheduler #(
   parameter int NUM_PX   = 384000,
   parameter int MAX_ITER = 64,
   parameter int PXC_W    = 19
) (
   input  logic         i_Clk,
   input  logic         i_Reset,
   input  logic         i_Start,
   input  logic         i_Julia,
   input  logic         i_Fill_Full,
   input  logic         i_Math_Ack,
   output logic [103:0] o_Fill_Data,
   output logic         o_Fill_Wrreq,
   output logic         o_Hold,
   output logic [1:0]   o_Draw,
   output logic         o_Busy,
   output logic         o_Frame_Done,
   output logic [15:0]  o_Pass
);

   localparam logic [1:0]       DRAW_CLEAR      = 2'd0;
   localparam logic [1:0]       DRAW_MANDELBROT = 2'd1;
   localparam logic [1:0]       DRAW_JULIA      = 2'd2;
   localparam logic [PXC_W-1:0] LP_PX_LAST      = PXC_W'(NUM_PX - 1);
   localparam logic [15:0]      LP_MAX_ITER     = 16'(MAX_ITER);

   typedef enum logic [2:0] {S_FILL, S_IDLE, S_CLEAR, S_ITER, S_DONE} state_t;

   state_t           r_state;
   logic [PXC_W-1:0] r_px_cnt;
   logic             r_julia;

   logic             w_px_last;
   logic [15:0]      w_pass_inc;
   logic [1:0]       w_mode_draw;

   assign w_px_last    = (r_px_cnt == LP_PX_LAST);
   assign w_pass_inc   = o_Pass + 16'd1;
   assign w_mode_draw  = r_julia ? DRAW_JULIA : DRAW_MANDELBROT;
   assign o_Fill_Data  = {8'h80, 32'h0, 32'h0, 32'h0};
   assign o_Fill_Wrreq = (r_state == S_FILL) & ~i_Fill_Full;

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_state      <= S_FILL;
         r_px_cnt     <= '0;
         r_julia      <= 1'b0;
         o_Hold       <= 1'b1;
         o_Draw       <= DRAW_CLEAR;
         o_Busy       <= 1'b0;
         o_Frame_Done <= 1'b0;
         o_Pass       <= 16'd0;
      end else begin
         o_Frame_Done <= 1'b0;
         case (r_state)
            S_FILL: begin
               if (o_Fill_Wrreq) begin
                  if (w_px_last) begin
                     r_px_cnt <= '0;
                     r_state  <= S_IDLE;
                  end else begin
                     r_px_cnt <= r_px_cnt + 1'b1;
                  end
               end
            end
            S_IDLE: begin
               if (i_Start) begin
                  r_julia <= i_Julia;
                  o_Pass  <= 16'd0;
                  o_Draw  <= DRAW_CLEAR;
                  o_Hold  <= 1'b0;
                  o_Busy  <= 1'b1;
                  r_state <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               if (i_Math_Ack) begin
                  if (w_px_last) begin
                     r_px_cnt <= '0;
                     o_Draw   <= w_mode_draw;
                     r_state  <= S_ITER;
                  end else begin
                     r_px_cnt <= r_px_cnt + 1'b1;
                  end
               end
            end
            S_ITER: begin
               if (i_Math_Ack) begin
                  if (w_px_last) begin
                     r_px_cnt <= '0;
                     o_Pass   <= w_pass_inc;
                     if (w_pass_inc == LP_MAX_ITER) begin
                        o_Hold       <= 1'b1;
                        o_Busy       <= 1'b0;
                        o_Frame_Done <= 1'b1;
                        r_state      <= S_DONE;
                     end
                  end else begin
                     r_px_cnt <= r_px_cnt + 1'b1;
                  end
               end
            end
            S_DONE: begin
`ifdef MFS_AUTO_REDRAW_EN
               // Restart as if i_Start fired, alternating the fractal each frame.
               r_julia <= ~r_julia;
               o_Pass  <= 16'd0;
               o_Draw  <= DRAW_CLEAR;
               o_Hold  <= 1'b0;
               o_Busy  <= 1'b1;
               r_state <= S_CLEAR;
`else
               r_state <= S_IDLE;
`endif
            end
            default: r_state <= S_FILL;
         endcase
      end
   end

endmodule
